// File: rtl/alu_pkg.sv
// Shared types for the decode-to-ALU control interface: op codes, operand
// selects, RV32I opcode values and the decoded entry carried by the skid buffer.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_AND  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        OP_A_RS1  = 2'b00,
        OP_A_PC   = 2'b01,
        OP_A_ZERO = 2'b10
    } op_a_sel_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic              insn_vld;
        alu_op_e           alu_op;
        op_a_sel_e         op_a_sel;
        logic              op_b_sel;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic              rd_wren;
        logic [DATA_W-1:0] pc;
    } dec_t;

    // funct3 mapping shared by OP and OP-IMM when funct7 is the base encoding.
    function automatic alu_op_e base_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: picks the I/S/B/U/J format from the opcode and
// flags OP-IMM shifts, whose immediate is the zero-extended shift amount.
module imm_gen
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] imm,
    output logic              is_shamt
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        imm      = '0;
        is_shamt = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    is_shamt = 1'b1;
                    imm      = {27'b0, instr[24:20]};
                end else begin
                    imm = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/id_alu_ctrl.sv
// Decode stage producing ALU control for execute; the decoded entry is
// registered through a 2-entry skid buffer so o_ready comes from a flop.
module id_alu_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = DATA_W
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [3:0]      o_alu_op,
    output logic [1:0]      o_op_a_sel,
    output logic            o_op_b_sel,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic [4:0]      o_rd_addr,
    output logic            o_rd_wren,
    output logic            o_insn_vld,
    output logic [XLEN-1:0] o_pc
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b10
    } state_e;

    logic [DATA_W-1:0] instr;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] gen_imm;
    logic              is_shamt;
    logic              legal;
    logic              writes_rd;
    dec_t              dec;

    assign instr  = DATA_W'(i_instr);
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    imm_gen u_imm_gen (
        .instr    (instr),
        .imm      (gen_imm),
        .is_shamt (is_shamt)
    );

    always_comb begin
        dec          = '0;
        legal        = 1'b0;
        writes_rd    = 1'b0;
        dec.alu_op   = ALU_ADD;
        dec.op_a_sel = OP_A_RS1;
        dec.op_b_sel = 1'b0;
        case (opcode)
            OPC_OP: begin
                writes_rd = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal      = 1'b1;
                    dec.alu_op = base_op(funct3);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal      = 1'b1;
                    dec.alu_op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                writes_rd    = 1'b1;
                dec.op_b_sel = 1'b1;
                // Only shifts use funct7; ADDI and friends ignore those bits.
                if (!is_shamt || funct7 == F7_BASE) begin
                    legal      = 1'b1;
                    dec.alu_op = base_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    legal      = 1'b1;
                    dec.alu_op = ALU_SRA;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                legal        = 1'b1;
                writes_rd    = 1'b1;
                dec.op_b_sel = 1'b1;
            end
            OPC_STORE: begin
                legal        = 1'b1;
                dec.op_b_sel = 1'b1;
            end
            OPC_LUI: begin
                legal        = 1'b1;
                writes_rd    = 1'b1;
                dec.op_a_sel = OP_A_ZERO;
                dec.op_b_sel = 1'b1;
            end
            OPC_AUIPC, OPC_JAL: begin
                legal        = 1'b1;
                writes_rd    = 1'b1;
                dec.op_a_sel = OP_A_PC;
                dec.op_b_sel = 1'b1;
            end
            OPC_BRANCH: begin
                legal        = 1'b1;
                dec.op_a_sel = OP_A_PC;
                dec.op_b_sel = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // Illegal words still travel down the pipe, just neutralised.
        if (!legal) begin
            dec.alu_op   = ALU_ADD;
            dec.op_a_sel = OP_A_RS1;
            dec.op_b_sel = 1'b0;
        end
        dec.insn_vld = legal;
        dec.imm      = legal ? gen_imm : '0;
        dec.rs1_addr = instr[19:15];
        dec.rs2_addr = instr[24:20];
        dec.rd_addr  = instr[11:7];
        dec.rd_wren  = legal & writes_rd & (instr[11:7] != 5'd0);
        dec.pc       = DATA_W'(i_pc);
    end

    state_e state_q, state_d;
    logic   ready_q, valid_q;
    logic   accept, consume;
    logic   load_out, load_skid, out_from_skid;
    dec_t   out_q, skid_q;

    assign accept  = i_valid & ready_q;
    assign consume = valid_q & i_ready;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (i_flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d  = S_ONE;
                        load_out = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && !consume) begin
                        state_d   = S_FULL;
                        load_skid = 1'b1;
                    end else if (consume && !accept) begin
                        state_d = S_EMPTY;
                    end else if (accept && consume) begin
                        load_out = 1'b1;
                    end
                end
                S_FULL: begin
                    if (consume) begin
                        state_d       = S_ONE;
                        out_from_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != S_FULL);
            valid_q <= (state_d != S_EMPTY);
            if (load_out) begin
                out_q <= dec;
            end else if (out_from_skid) begin
                out_q <= skid_q;
            end
        end
    end

    // NOTE: the skid entry has no reset; it is only read after being loaded
    // in FULL, and reset/flush always leave the buffer EMPTY.
    always_ff @(posedge i_clk) begin
        if (load_skid) begin
            skid_q <= dec;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_alu_op   = out_q.alu_op;
    assign o_op_a_sel = out_q.op_a_sel;
    assign o_op_b_sel = out_q.op_b_sel;
    assign o_imm      = XLEN'(out_q.imm);
    assign o_rs1_addr = out_q.rs1_addr;
    assign o_rs2_addr = out_q.rs2_addr;
    assign o_rd_addr  = out_q.rd_addr;
    assign o_rd_wren  = out_q.rd_wren;
    assign o_insn_vld = out_q.insn_vld;
    assign o_pc       = XLEN'(out_q.pc);

endmodule

// File: doc/id_alu_ctrl.md
Name: id_alu_ctrl

Overview:
- Decode-side producer of the ALU control interface for the RV32I core.
- Takes a fetched instruction and PC over a valid/ready handshake and decodes it into the ALU op code, operand selects, immediate and register addresses.
- Registers the result through a 2-entry skid buffer, so decode runs at full throughput with a registered o_ready.
- Output feeds the execute stage, which drives i_alu_op and the operand muxes of the ALU.

Parameters:
- XLEN, 32, datapath width for instruction, PC and immediate.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_instr  input  XLEN  instruction word.
- i_pc  input  XLEN  PC of i_instr.
- i_valid  input  1  upstream has an instruction.
- o_ready  output  1  block can accept this cycle.
- i_flush  input  1  discard all buffered entries.
- o_valid  output  1  decoded entry presented.
- i_ready  input  1  downstream accepts this cycle.
- o_alu_op  output  4  ALU op code.
- o_op_a_sel  output  2  operand A select: 00 rs1, 01 pc, 10 zero.
- o_op_b_sel  output  1  operand B select: 0 rs2, 1 imm.
- o_imm  output  XLEN  decoded immediate.
- o_rs1_addr  output  5  source register 1 address.
- o_rs2_addr  output  5  source register 2 address.
- o_rd_addr  output  5  destination register address.
- o_rd_wren  output  1  register write enable.
- o_insn_vld  output  1  instruction is legal.
- o_pc  output  XLEN  PC passthrough.

Behaviour:
- ALU op codes (fixed, must match the ALU):
  - ADD 0000, SUB 0001, SLT 0010, SLTU 0011, XOR 0100.
  - OR 0101, AND 0110, SLL 0111, SRL 1000, SRA 1001.
- Handshake:
  - Input accepted when i_valid & o_ready.
  - Output consumed when o_valid & i_ready.
  - o_valid and the data outputs are stable while o_valid & ~i_ready.
- Skid buffer FSM, states EMPTY / ONE / FULL:
  - EMPTY: accept -> ONE.
  - ONE: accept & ~consume -> FULL; consume & ~accept -> EMPTY; accept & consume -> ONE, with the new entry presented next cycle.
  - FULL: consume -> ONE, with the skid entry moving to the output register.
  - o_ready is registered: 0 exactly in FULL.
  - o_valid is 1 in ONE and FULL.
- Latency: 1 cycle from accept to o_valid when EMPTY, or when ONE with a simultaneous consume.
- Order is preserved. No entry is ever dropped or duplicated except by flush or reset.
- Flush:
  - i_flush -> next cycle EMPTY, o_valid=0, o_ready=1.
  - An input handshaking in the flush cycle is discarded.
  - Flush wins over a simultaneous accept and consume.
- Reset:
  - i_reset -> next cycle EMPTY, o_valid=0, o_ready=1.
  - All data outputs are 0.
  - Handshakes in reset cycles are ignored.
  - Reset mid-transfer loses all buffered entries.
- Decode by opcode:
  - OP (0110011): funct3/funct7 select ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Any other funct7 is illegal. a_sel=00, b_sel=0.
  - OP-IMM (0010011): same mapping, except funct3=000 is always ADD. For shifts, funct7 must be 0000000, or 0100000 for SRAI; otherwise illegal. o_imm = zero-extended instr[24:20]. a_sel=00, b_sel=1.
  - LOAD, STORE, JALR: ADD, a=rs1, b=imm.
  - LUI: ADD, a=zero, b=imm.
  - AUIPC, JAL, BRANCH: ADD, a=pc, b=imm, giving the target address.
- o_rd_wren is 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR, and is forced to 0 when rd=0.
- Immediates: I/S/B/U/J formats, sign-extended per the RV32I spec.
- Illegal or unknown opcode: o_insn_vld=0, o_alu_op=ADD, o_rd_wren=0, o_imm=0. The entry still flows through the handshake.

Decomposition:
- Package alu_pkg:
  - alu_op_e, holding the op codes above.
  - Opcode localparams.
  - op_a_sel_e.
  - Struct dec_t with all decoded output fields, used for both buffer entries.
- Sub-module imm_gen:
  - Combinational.
  - Inputs: instruction. Output: sign-extended immediate plus a shift-immediate flag.

Test Plan:
- 0x002081B3 (add x3,x1,x2) -> next cycle o_valid=1, alu_op=0000, rs1=1, rs2=2, rd=3, a_sel=00, b_sel=0, rd_wren=1.
- 0x407302B3 (sub x5,x6,x7) -> alu_op=0001. 0x40315093 (srai x1,x2,3) -> alu_op=1001, b_sel=1, imm=0x3.
- 0x123450B7 (lui x1,0x12345) -> alu_op=0000, a_sel=10, imm=0x12345000. 0xFFFFFFFF -> insn_vld=0, rd_wren=0, alu_op=0000.
- i_ready=0, push 3 back-to-back -> 2 accepted, o_ready=0 after the 2nd accept; raise i_ready -> entries 1 and 2 drain in order on consecutive cycles, then the 3rd is accepted.
- State FULL, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, flushed input never appears.
- Stream 8 instructions with i_ready=1 continuously -> one output per cycle, 1-cycle latency, in order; mid-stream i_reset -> next cycle o_valid=0, outputs 0.
